// File: rtl/ema_sample_feeder.sv
// rtl/ema_sample_feeder.sv - sample FIFO and issuer in front of the EMA filter, with a completion watchdog
// Optional macro EMA_FEED_DROPCNT_EN adds drop_cnt_o, a saturating count of samples offered while full.
module ema_sample_feeder #(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   s_data_i,
    input  logic          s_valid_i,
    output logic          s_ready_o,
    output logic [15:0]   x_o,
    output logic          valid_o,
    input  logic          bussy_i,
    input  logic          done_i,
    output logic [AW:0]   level_o,
    output logic          err_o
`ifdef EMA_FEED_DROPCNT_EN
    ,
    output logic [15:0]   drop_cnt_o
`endif
);

    localparam int WW = $clog2(TIMEOUT);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
    localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level_nxt;
    logic [WW-1:0] wdog;
    logic [0:0]    state;
    logic          push;
    logic          pop;

    assign push = s_valid_i && s_ready_o;
    // Pop decision uses the registered level, so a sample pushed this edge cannot bypass the FIFO.
    assign pop  = (state == S_IDLE) && (level_o != '0) && !bussy_i;

    always_comb begin
        level_nxt = level_o;
        if (push && !pop)
            level_nxt = level_o + (AW+1)'(1);
        else if (!push && pop)
            level_nxt = level_o - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= s_data_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level_o   <= '0;
            s_ready_o <= 1'b1;
            x_o       <= '0;
            valid_o   <= 1'b0;
            err_o     <= 1'b0;
            wdog      <= '0;
            state     <= S_IDLE;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            level_o   <= level_nxt;
            s_ready_o <= (level_nxt != FULL);
            valid_o   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        x_o     <= mem[rd_ptr];
                        valid_o <= 1'b1;
                        wdog    <= '0;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (done_i) begin
                        state <= S_IDLE;
                    end else if (wdog == WD_LAST) begin
                        // The outstanding sample is abandoned; the queue keeps flowing.
                        err_o <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        wdog <= wdog + WW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef EMA_FEED_DROPCNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            drop_cnt_o <= '0;
        else if (s_valid_i && !s_ready_o && (drop_cnt_o != 16'hFFFF))
            drop_cnt_o <= drop_cnt_o + 16'd1;
    end
`endif

endmodule
